fifo_uart_transmitter: RTL and testbench

//  Drains bytes from a fifo instance over its push/pop handshake and serialises each one

---
 rtl/fifo_uart_transmitter.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_transmitter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_transmitter.sv
// Pops one byte per frame from a fifo and serialises it onto an RS232 TX line.
// Start bit, DATA_WIDTH data bits LSB first, optional parity, then STOP_BITS stop bits.
module fifo_uart_transmitter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int POP_HOLD   = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  fifo_popped_last,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_sent
);
  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int BW        = $clog2(DATA_WIDTH + STOP_BITS + 1);
  localparam logic [31:0]   LAST_TICK = 32'(BIT_TICKS - 1);
  localparam logic [31:0]   POP_LAST  = 32'(POP_HOLD - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP_REQ, S_POP_WAIT, S_LATCH, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    tick_end;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tick_end = (tick_q == LAST_TICK);
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (enable && !fifo_popped_last) state_d = S_POP_REQ;
      end
      S_POP_REQ: begin
        if (tick_q == POP_LAST) begin
          tick_d  = '0;
          state_d = S_POP_WAIT;
        end else tick_d = tick_q + 32'd1;
      end
      // two quiet cycles so the fifo can settle out_data and popped_last
      S_POP_WAIT: begin
        if (tick_q == 32'd1) begin
          tick_d  = '0;
          state_d = S_LATCH;
        end else tick_d = tick_q + 32'd1;
      end
      S_LATCH: begin
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ (PARITY == 1);
        tick_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (tick_end) begin
          tick_d  = '0;
          state_d = S_DATA;
        end else tick_d = tick_q + 32'd1;
      end
      S_DATA: begin
        if (tick_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 32'd1;
      end
      S_PARITY: begin
        if (tick_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else tick_d = tick_q + 32'd1;
      end
      S_STOP: begin
        if (tick_end) begin
          tick_d = '0;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line bit lines up with the state
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign fifo_pop  = (state_q == S_POP_REQ);
  assign busy      = (state_q != S_IDLE);
  assign byte_sent = (state_q == S_STOP) && tick_end && (bit_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_transmitter.sv
// Bench: three transmitter flavours share one fifo model; frames are checked cycle by cycle.
module tb_fifo_uart_transmitter;
  localparam int BT = 10;

  typedef struct {
    logic [1:0] inst;
    logic [7:0] data;
    int         par;    // -1 = no parity bit, else expected parity bit
    int         stops;
    bit         first;
    bit         last;
  } vec_t;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [7:0] fdata = 8'h00;
  logic       empty = 1'b1;
  logic       pop_prev = 1'b0;
  logic [7:0] qd[$];
  logic [2:0] pop, tx, busy, bsent, pl;
  logic       pop_m, tx_m, busy_m, bsent_m;
  int         nchk = 0;
  int         nerr = 0;
  vec_t       v[6];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_pl
    assign pl[k] = (sel != 2'(k)) || empty;
  end
  assign pop_m   = pop[sel];
  assign tx_m    = tx[sel];
  assign busy_m  = busy[sel];
  assign bsent_m = bsent[sel];

  fifo_uart_transmitter #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY(0), .STOP_BITS(1), .POP_HOLD(3)) u0 (
    .clk(clk), .clear(clear), .enable(enable), .fifo_popped_last(pl[0]), .fifo_data(fdata),
    .fifo_pop(pop[0]), .tx(tx[0]), .busy(busy[0]), .byte_sent(bsent[0]));
  fifo_uart_transmitter #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY(2), .STOP_BITS(2), .POP_HOLD(3)) u1 (
    .clk(clk), .clear(clear), .enable(enable), .fifo_popped_last(pl[1]), .fifo_data(fdata),
    .fifo_pop(pop[1]), .tx(tx[1]), .busy(busy[1]), .byte_sent(bsent[1]));
  fifo_uart_transmitter #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY(1), .STOP_BITS(1), .POP_HOLD(3)) u2 (
    .clk(clk), .clear(clear), .enable(enable), .fifo_popped_last(pl[2]), .fifo_data(fdata),
    .fifo_pop(pop[2]), .tx(tx[2]), .busy(busy[2]), .byte_sent(bsent[2]));

  // fifo model: the rising edge of a pop presents the head on out_data
  always @(posedge clk) begin
    pop_prev <= pop_m;
    if (pop_m && !pop_prev && qd.size() != 0) fdata <= qd.pop_front();
    empty <= (qd.size() == 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ebit(input int idx, input logic [7:0] d, input int par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par >= 0) return par[0];
    return 1'b1;
  endfunction

  task automatic rx_frame(input logic [7:0] d, input int par, input int stops, input bit chk_gap);
    int gap = 0, pops = 0, nb, bad = 0, bsbad = 0;
    logic [7:0] got = 8'h00;
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_m == 1'b0) begin
        seen = 1'b1;
        break;
      end
      gap++;
      if (pop_m) pops++;
    end
    check("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("pop_len", pops, 3);
    if (chk_gap) check("gap", gap, 7);
    nb = 9 + ((par >= 0) ? 1 : 0) + stops;
    for (int c = 1; c < nb * BT; c++) begin
      @(negedge clk);
      if (tx_m !== ebit(c / BT, d, par)) bad++;
      if (bsent_m !== (c == nb * BT - 1)) bsbad++;
      if (pop_m || busy_m !== 1'b1) bad++;
      if (c % BT == BT / 2 && c / BT >= 1 && c / BT <= 8) got[c / BT - 1] = tx_m;
    end
    check("frame_bits", bad, 0);
    check("byte_sent", bsbad, 0);
    check("rx_data", got, d);
  endtask

  initial begin
    int pops, lows;
    v[0] = '{2'd0, 8'h55, -1, 1, 1'b1, 1'b1};
    v[1] = '{2'd0, 8'hA5, -1, 1, 1'b1, 1'b0};
    v[2] = '{2'd0, 8'h3C, -1, 1, 1'b0, 1'b0};
    v[3] = '{2'd0, 8'hFF, -1, 1, 1'b0, 1'b1};
    v[4] = '{2'd1, 8'h07,  1, 2, 1'b1, 1'b1};
    v[5] = '{2'd2, 8'h07,  0, 1, 1'b1, 1'b1};

    // reset with an empty fifo
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'h7);
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bsent", 32'(bsent), 32'h0);
    clear = 1'b0;
    pops = 0;
    lows = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (pop != 3'b000) pops++;
      if (tx != 3'b111 || busy != 3'b000) lows++;
    end
    check("empty_no_pop", pops, 0);
    check("empty_idle", lows, 0);

    // table: single byte, burst, parity/stop variants
    for (int i = 0; i < 6; i++) begin
      if (v[i].first) begin
        sel = v[i].inst;
        for (int j = i; j < 6; j++) begin
          if (j != i && v[j].first) break;
          qd.push_back(v[j].data);
        end
      end
      rx_frame(v[i].data, v[i].par, v[i].stops, !v[i].first);
      if (v[i].last) begin
        @(negedge clk);
        check("idle_busy", 32'(busy_m), 32'd0);
        check("idle_tx", 32'(tx_m), 32'd1);
      end
    end

    // enable drops during the data bits of the first of two queued bytes
    sel = 2'd0;
    qd.push_back(8'h11);
    qd.push_back(8'h22);
    fork
      rx_frame(8'h11, -1, 1, 1'b0);
      begin
        repeat (30) @(negedge clk);
        enable = 1'b0;
      end
    join
    pops = 0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pop_m) pops++;
      if (busy_m || !tx_m) lows++;
    end
    check("dis_no_pop", pops, 0);
    check("dis_idle", lows, 0);
    enable = 1'b1;
    rx_frame(8'h22, -1, 1, 1'b0);

    // clear in the middle of a frame, remaining bytes still go out intact
    qd.push_back(8'h81);
    qd.push_back(8'h42);
    qd.push_back(8'h99);
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_m == 1'b0) begin
        lows = 1;
        break;
      end
    end
    check("clr_start", lows, 1);
    repeat (39) @(negedge clk);
    check("clr_pre_tx", 32'(tx_m), 32'd0);
    clear = 1'b1;
    @(negedge clk);
    check("clr_tx", 32'(tx_m), 32'd1);
    check("clr_busy", 32'(busy_m), 32'd0);
    check("clr_pop", 32'(pop_m), 32'd0);
    clear = 1'b0;
    rx_frame(8'h42, -1, 1, 1'b0);
    rx_frame(8'h99, -1, 1, 1'b1);
    @(negedge clk);
    check("end_busy", 32'(busy_m), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
